decode_stage: RTL and testbench

Pipeline decode stage sitting directly downstream of the fetch stage. It takes the fetch stage's registered `valid`/`pc`/`next_pc` together with the instruction word returned on the instruction memory read port. It also holds a returned instruction across stalls so the word is never lost. It decodes RV64I fields and sign-extended immediates, and presents them in a stall/bubble/squash-aware pipeline register bank to the execute stage.

---
 rtl/decode_stage.sv | 134 +++++++++++++
 tb/tb_decode_stage.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV64I decode stage: holds a returned instruction word across stalls, decodes fields and
// immediates, and registers them for execute with stall/bubble/squash handling.
module decode_stage (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        squash_i,
   input  logic        bubble_i,
   input  logic        stall_i,
   input  logic        valid_i,
   input  logic [63:0] pc_i,
   input  logic [63:0] next_pc_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        imem_rvalid_i,
   output logic [4:0]  rs1_addr_o,
   output logic [4:0]  rs2_addr_o,
   output logic        valid_o,
   output logic [63:0] pc_o,
   output logic [63:0] next_pc_o,
   output logic [31:0] inst_o,
   output logic [6:0]  opcode_o,
   output logic [2:0]  funct3_o,
   output logic        funct7b5_o,
   output logic [4:0]  rd_addr_o,
   output logic [4:0]  rs1_o,
   output logic [4:0]  rs2_o,
   output logic [63:0] imm_o,
   output logic        illegal_o
);

   localparam logic [6:0] OpLoad    = 7'b0000011;
   localparam logic [6:0] OpMiscMem = 7'b0001111;
   localparam logic [6:0] OpOpImm   = 7'b0010011;
   localparam logic [6:0] OpAuipc   = 7'b0010111;
   localparam logic [6:0] OpOpImm32 = 7'b0011011;
   localparam logic [6:0] OpStore   = 7'b0100011;
   localparam logic [6:0] OpOp      = 7'b0110011;
   localparam logic [6:0] OpLui     = 7'b0110111;
   localparam logic [6:0] OpOp32    = 7'b0111011;
   localparam logic [6:0] OpBranch  = 7'b1100011;
   localparam logic [6:0] OpJalr    = 7'b1100111;
   localparam logic [6:0] OpJal     = 7'b1101111;
   localparam logic [6:0] OpSystem  = 7'b1110011;

   logic [31:0] hold_q;
   logic        hold_v_q;
   logic        sq_stall_q;
   logic [31:0] inst;
   logic        kill;
   logic [63:0] imm_d;
   logic [4:0]  rd_d;
   logic        illegal_d;

   assign inst       = hold_v_q ? hold_q : imem_rdata_i;
   assign kill       = squash_i | sq_stall_q | bubble_i;
   assign rs1_addr_o = inst[19:15];
   assign rs2_addr_o = inst[24:20];

   always_comb begin
      imm_d     = '0;
      rd_d      = inst[11:7];
      illegal_d = 1'b0;
      case (inst[6:0])
         OpLoad, OpOpImm, OpOpImm32, OpJalr, OpSystem:
            imm_d = {{52{inst[31]}}, inst[31:20]};
         OpStore: begin
            imm_d = {{52{inst[31]}}, inst[31:25], inst[11:7]};
            rd_d  = '0;
         end
         OpBranch: begin
            imm_d = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            rd_d  = '0;
         end
         OpLui, OpAuipc:
            imm_d = {{32{inst[31]}}, inst[31:12], 12'b0};
         OpJal:
            imm_d = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         OpOp, OpOp32, OpMiscMem:
            imm_d = '0;
         default:
            illegal_d = 1'b1;
      endcase
      if (inst[1:0] != 2'b11) illegal_d = 1'b1;
      if (illegal_d) rd_d = '0;
   end

   // Word arriving during a stall is parked until the first non-stall edge consumes it.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hold_q     <= '0;
         hold_v_q   <= 1'b0;
         sq_stall_q <= 1'b0;
      end else if (stall_i) begin
         if (imem_rvalid_i) begin
            hold_q   <= imem_rdata_i;
            hold_v_q <= 1'b1;
         end
         if (squash_i) sq_stall_q <= 1'b1;
      end else begin
         hold_v_q   <= 1'b0;
         sq_stall_q <= 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_o    <= 1'b0;
         pc_o       <= '0;
         next_pc_o  <= '0;
         inst_o     <= 32'h0000_0013;
         opcode_o   <= 7'h13;
         funct3_o   <= '0;
         funct7b5_o <= 1'b0;
         rd_addr_o  <= '0;
         rs1_o      <= '0;
         rs2_o      <= '0;
         imm_o      <= '0;
         illegal_o  <= 1'b0;
      end else if (!stall_i) begin
         valid_o    <= kill ? 1'b0 : valid_i;
         pc_o       <= pc_i;
         next_pc_o  <= next_pc_i;
         inst_o     <= inst;
         opcode_o   <= inst[6:0];
         funct3_o   <= inst[14:12];
         funct7b5_o <= inst[30];
         rd_addr_o  <= rd_d;
         rs1_o      <= inst[19:15];
         rs2_o      <= inst[24:20];
         imm_o      <= imm_d;
         illegal_o  <= illegal_d;
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Randomized and directed bench for decode_stage against a behavioural reference model.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst_i, squash_i, bubble_i, stall_i, valid_i, imem_rvalid_i;
   logic [63:0] pc_i, next_pc_i;
   logic [31:0] imem_rdata_i;
   logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o, rs1_o, rs2_o;
   logic        valid_o, funct7b5_o, illegal_o;
   logic [63:0] pc_o, next_pc_o, imm_o;
   logic [31:0] inst_o;
   logic [6:0]  opcode_o;
   logic [2:0]  funct3_o;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   logic [31:0] m_hold;
   logic        m_hold_v, m_sq;
   logic        e_valid, e_ill;
   logic [63:0] e_pc, e_npc, e_imm;
   logic [31:0] e_inst;
   logic [4:0]  e_rd;

   decode_stage dut (
      .clk_i(clk), .rst_i(rst_i), .squash_i(squash_i), .bubble_i(bubble_i),
      .stall_i(stall_i), .valid_i(valid_i), .pc_i(pc_i), .next_pc_i(next_pc_i),
      .imem_rdata_i(imem_rdata_i), .imem_rvalid_i(imem_rvalid_i),
      .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o), .valid_o(valid_o), .pc_o(pc_o),
      .next_pc_o(next_pc_o), .inst_o(inst_o), .opcode_o(opcode_o), .funct3_o(funct3_o),
      .funct7b5_o(funct7b5_o), .rd_addr_o(rd_addr_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
      .imm_o(imm_o), .illegal_o(illegal_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Immediate built with signed arithmetic on the word rather than bit concatenation.
   function automatic void ref_decode(input logic [31:0] w, output logic [63:0] imm,
                                      output logic [4:0] rd, output logic ill);
      longint s;
      logic [6:0] op;
      s   = longint'($signed(w));
      op  = w[6:0];
      imm = 64'd0;
      rd  = w[11:7];
      ill = 1'b0;
      if (op inside {7'h03, 7'h13, 7'h1b, 7'h67, 7'h73}) imm = s >>> 20;
      else if (op == 7'h23) begin
         imm = ((s >>> 25) <<< 5) | longint'(w[11:7]);
         rd  = 5'd0;
      end else if (op == 7'h63) begin
         imm = ((s >>> 31) <<< 12) | (longint'(w[7]) << 11) | (longint'(w[30:25]) << 5)
               | (longint'(w[11:8]) << 1);
         rd  = 5'd0;
      end else if (op inside {7'h37, 7'h17}) imm = s & ~64'hfff;
      else if (op == 7'h6f)
         imm = ((s >>> 31) <<< 20) | (longint'(w[19:12]) << 12) | (longint'(w[20]) << 11)
               | (longint'(w[30:21]) << 1);
      else if (!(op inside {7'h33, 7'h3b, 7'h0f})) ill = 1'b1;
      if (ill) rd = 5'd0;
   endfunction

   task automatic model_reset();
      m_hold_v = 1'b0; m_sq = 1'b0; m_hold = '0;
      e_valid = 1'b0; e_pc = '0; e_npc = '0; e_inst = 32'h13; e_imm = '0; e_rd = '0;
      e_ill = 1'b0;
   endtask

   task automatic model_edge();
      logic [31:0] w;
      logic [63:0] imm;
      logic [4:0]  rd;
      logic        ill;
      if (stall_i) begin
         if (imem_rvalid_i) begin
            m_hold = imem_rdata_i; m_hold_v = 1'b1;
         end
         if (squash_i) m_sq = 1'b1;
      end else begin
         w = m_hold_v ? m_hold : imem_rdata_i;
         ref_decode(w, imm, rd, ill);
         e_valid = (squash_i || m_sq || bubble_i) ? 1'b0 : valid_i;
         e_pc = pc_i; e_npc = next_pc_i; e_inst = w; e_imm = imm; e_rd = rd; e_ill = ill;
         m_hold_v = 1'b0; m_sq = 1'b0;
      end
   endtask

   task automatic check_outputs();
      check("valid", 64'(valid_o), 64'(e_valid));
      check("pc", pc_o, e_pc);
      check("next_pc", next_pc_o, e_npc);
      check("inst", 64'(inst_o), 64'(e_inst));
      check("opcode", 64'(opcode_o), 64'(e_inst[6:0]));
      check("funct3", 64'(funct3_o), 64'(e_inst[14:12]));
      check("funct7b5", 64'(funct7b5_o), 64'(e_inst[30]));
      check("rd", 64'(rd_addr_o), 64'(e_rd));
      check("rs1", 64'(rs1_o), 64'(e_inst[19:15]));
      check("rs2", 64'(rs2_o), 64'(e_inst[24:20]));
      check("imm", imm_o, e_imm);
      check("illegal", 64'(illegal_o), 64'(e_ill));
   endtask

   // Called just after a rising edge; drives inputs, checks the read ports, clocks, checks.
   task automatic cycle(input logic v, input logic [63:0] pc, input logic [31:0] rd,
                        input logic rv, input logic st, input logic sq, input logic bb);
      logic [31:0] sel;
      valid_i = v; pc_i = pc; next_pc_i = pc + 64'd4; imem_rdata_i = rd;
      imem_rvalid_i = rv; stall_i = st; squash_i = sq; bubble_i = bb;
      #1;
      sel = m_hold_v ? m_hold : imem_rdata_i;
      check("rs1_addr", 64'(rs1_addr_o), 64'(sel[19:15]));
      check("rs2_addr", 64'(rs2_addr_o), 64'(sel[24:20]));
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   function automatic logic [31:0] rand_inst();
      logic [6:0] ops [13] = '{7'h03, 7'h0f, 7'h13, 7'h17, 7'h1b, 7'h23, 7'h33, 7'h37,
                                7'h3b, 7'h63, 7'h67, 7'h6f, 7'h73};
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(9) == 0) return r;
      return {r[31:7], ops[$urandom_range(12)]};
   endfunction

   initial begin
      logic prev_v;
      rst_i = 1'b1; squash_i = 0; bubble_i = 0; stall_i = 0; valid_i = 0;
      imem_rvalid_i = 0; pc_i = '0; next_pc_i = '0; imem_rdata_i = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs();
      rst_i = 1'b0;

      // Basic decode
      cycle(1, 64'h1000, 32'h0050_0093, 1, 0, 0, 0);
      check("addi_valid", 64'(valid_o), 64'd1);
      check("addi_pc", pc_o, 64'h1000);
      check("addi_rd", 64'(rd_addr_o), 64'd1);
      check("addi_imm", imm_o, 64'd5);
      check("addi_ill", 64'(illegal_o), 64'd0);

      // Immediate formats
      cycle(1, 64'h1004, 32'hFE11_2E23, 1, 0, 0, 0);
      check("store_imm", imm_o, 64'hFFFF_FFFF_FFFF_FFFC);
      check("store_rd", 64'(rd_addr_o), 64'd0);
      cycle(1, 64'h1008, 32'hFE00_0EE3, 1, 0, 0, 0);
      check("branch_imm", imm_o, 64'hFFFF_FFFF_FFFF_FFFC);
      cycle(1, 64'h100c, 32'h0080_006F, 1, 0, 0, 0);
      check("jal_imm", imm_o, 64'd8);
      cycle(1, 64'h1010, 32'h8000_00B7, 1, 0, 0, 0);
      check("lui_imm", imm_o, 64'hFFFF_FFFF_8000_0000);

      // Stall capture over three cycles
      cycle(1, 64'h1014, 32'h0020_8133, 1, 1, 0, 0);
      check("stall_frozen", 64'(inst_o), 64'h8000_00B7);
      cycle(1, 64'h1014, 32'hDEAD_BEEF, 0, 1, 0, 0);
      cycle(1, 64'h1014, 32'h1234_5678, 0, 1, 0, 0);
      cycle(1, 64'h1014, 32'hCAFE_F00D, 0, 0, 0, 0);
      check("stall_inst", 64'(inst_o), 64'h0020_8133);
      check("stall_rs1", 64'(rs1_o), 64'd1);
      check("stall_rs2", 64'(rs2_o), 64'd2);
      check("stall_rd", 64'(rd_addr_o), 64'd2);

      // Squash in cycle 2 of a 4-cycle stall
      prev_v = valid_o;
      cycle(1, 64'h2000, 32'h0010_0113, 1, 1, 0, 0);
      cycle(1, 64'h2000, 32'h0, 0, 1, 1, 0);
      cycle(1, 64'h2000, 32'h0, 0, 1, 0, 0);
      cycle(1, 64'h2000, 32'h0, 0, 1, 0, 0);
      check("sq_stall_hold", 64'(valid_o), 64'(prev_v));
      cycle(1, 64'h2000, 32'h0, 0, 0, 0, 0);
      check("sq_release", 64'(valid_o), 64'd0);

      // Illegal and bubble
      cycle(1, 64'h3000, 32'h0000_0000, 1, 0, 0, 0);
      check("illegal_flag", 64'(illegal_o), 64'd1);
      check("illegal_rd", 64'(rd_addr_o), 64'd0);
      cycle(1, 64'h3004, 32'h0050_0093, 1, 0, 0, 1);
      check("bubble_valid", 64'(valid_o), 64'd0);

      // Async reset mid-stall, with a held word and a pending squash
      cycle(1, 64'h4000, 32'h0050_0093, 1, 0, 0, 0);
      cycle(1, 64'h4004, 32'h0020_8133, 1, 1, 1, 0);
      #2 rst_i = 1'b1;
      #1;
      model_reset();
      check("arst_valid", 64'(valid_o), 64'd0);
      check("arst_inst", 64'(inst_o), 64'h13);
      @(posedge clk);
      #1 rst_i = 1'b0;
      cycle(1, 64'h5000, 32'h0070_0193, 1, 0, 0, 0);
      check("post_rst_inst", 64'(inst_o), 64'h0070_0193);
      check("post_rst_valid", 64'(valid_o), 64'd1);

      // Randomized traffic
      for (int i = 0; i < 500; i++) begin
         cycle($urandom_range(9) < 8, {$urandom, $urandom}, rand_inst(),
               $urandom_range(1) == 1, $urandom_range(9) < 3, $urandom_range(9) == 0,
               $urandom_range(9) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
